// File: rtl/scoreboard_checker_pkg.sv
// Shared definitions for the in-order expected/measured scoreboard checker:
// FSM state encodings and the state transition helper.
package scoreboard_checker_pkg;

  localparam logic [1:0] SB_IDLE = 2'd0;
  localparam logic [1:0] SB_RUN  = 2'd1;
  localparam logic [1:0] SB_FAIL = 2'd2;

  // IDLE -> RUN on the first push, IDLE/RUN -> FAIL on any error; FAIL holds until reset.
  function automatic logic [1:0] sb_next_state(input logic [1:0] st,
                                               input logic       start,
                                               input logic       error);
    logic [1:0] nxt;
    nxt = st;
    case (st)
      SB_IDLE: begin
        if (error)      nxt = SB_FAIL;
        else if (start) nxt = SB_RUN;
      end
      SB_RUN: begin
        if (error) nxt = SB_FAIL;
      end
      default: nxt = SB_FAIL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scoreboard_checker_if.sv
// Expected/measured result streams feeding the scoreboard checker.
interface scoreboard_checker_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 exp_valid;
  logic [DATAWIDTH-1:0] exp_data;
  logic                 meas_valid;
  logic [DATAWIDTH-1:0] meas_data;

  modport master (
    output exp_valid, exp_data, meas_valid, meas_data
  );

  modport slave (
    input exp_valid, exp_data, meas_valid, meas_data
  );
endinterface

// File: rtl/scoreboard_checker_sb_fifo.sv
// Expected-value FIFO: synchronous write, combinational head read, occupancy counter
// for full/empty so the pointers can wrap freely.
module sb_fifo #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATAWIDTH-1:0]         din,
  output logic [DATAWIDTH-1:0]         dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/scoreboard_checker.sv
// In-order, latency-tolerant expected/measured response checker with error flags
// and saturating counters. Define SCOREBOARD_TIMEOUT_EN to add the stall timeout.
module scoreboard_checker
  import scoreboard_checker_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNTWIDTH  = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  scoreboard_checker_if.slave        sb,
  output logic                       err,
  output logic                       err_sticky,
  output logic [CNTWIDTH-1:0]        err_count,
  output logic [CNTWIDTH-1:0]        chk_count,
  output logic [DATAWIDTH-1:0]       first_exp,
  output logic [DATAWIDTH-1:0]       first_meas,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] pending
`ifdef SCOREBOARD_TIMEOUT_EN
  ,
  output logic                       timeout
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || CNTWIDTH < 1) begin : g_param_check
    $error("scoreboard_checker: DEPTH must be a power of 2 >= 2, TIMEOUT and CNTWIDTH >= 1");
  end

  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
    return (v == '1) ? v : v + CNTWIDTH'(1);
  endfunction

  logic                 exp_valid, meas_valid;
  logic [DATAWIDTH-1:0] exp_data, meas_data, head;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic                 mismatch_ev, underflow_ev, overflow_ev, timeout_ev, any_err;

  logic [1:0]           state_q, state_d;
  logic                 err_q, err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [CNTWIDTH-1:0]  err_count_q, err_count_d;
  logic [CNTWIDTH-1:0]  chk_count_q, chk_count_d;
  logic [DATAWIDTH-1:0] first_exp_q, first_exp_d;
  logic [DATAWIDTH-1:0] first_meas_q, first_meas_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  assign exp_valid  = sb.exp_valid;
  assign exp_data   = sb.exp_data;
  assign meas_valid = sb.meas_valid;
  assign meas_data  = sb.meas_data;

  // A push arriving with a measurement on an empty FIFO is enqueued, never compared.
  assign pop          = meas_valid & ~fifo_empty;
  assign push         = exp_valid;
  assign mismatch_ev  = pop & (head != meas_data);
  assign underflow_ev = meas_valid & fifo_empty;
  assign overflow_ev  = exp_valid & fifo_full & ~pop;
  assign any_err      = mismatch_ev | underflow_ev | overflow_ev | timeout_ev;

  sb_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (exp_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

`ifdef SCOREBOARD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    idle_d     = idle_q;
    timeout_ev = 1'b0;
    if (pop || fifo_empty) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT - 1)) begin
      idle_d     = '0;
      timeout_ev = 1'b1;
    end else begin
      idle_d = idle_q + TW'(1);
    end
    timeout_d = timeout_q | timeout_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_ev = 1'b0;
`endif

  always_comb begin
    state_d      = sb_next_state(state_q, exp_valid, any_err);
    err_d        = mismatch_ev | underflow_ev;
    err_sticky_d = err_sticky_q | any_err;
    overflow_d   = overflow_q | overflow_ev;
    underflow_d  = underflow_q | underflow_ev;
    chk_count_d  = pop ? sat_inc(chk_count_q) : chk_count_q;
    first_exp_d  = first_exp_q;
    first_meas_d = first_meas_q;

    // Mismatch, underflow and overflow are mutually exclusive; only timeout can stack.
    err_count_d = err_count_q;
    if (mismatch_ev | underflow_ev | overflow_ev) err_count_d = sat_inc(err_count_d);
    if (timeout_ev)                               err_count_d = sat_inc(err_count_d);

    if (mismatch_ev && state_q != SB_FAIL) begin
      first_exp_d  = head;
      first_meas_d = meas_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SB_IDLE;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      chk_count_q  <= '0;
      first_exp_q  <= '0;
      first_meas_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      chk_count_q  <= chk_count_d;
      first_exp_q  <= first_exp_d;
      first_meas_q <= first_meas_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign chk_count  = chk_count_q;
  assign first_exp  = first_exp_q;
  assign first_meas = first_meas_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
